fetch_unit: RTL

//   Hart-side instruction fetch stage directly upstream of the memory interconnector.

---
 rtl/fetch_unit.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one word request at a time to
// the memory interconnector, and buffers fetched words in a small FIFO whose
// head is registered toward decode. Redirects flush the buffer and discard any
// in-flight response.
// Optional build macro: FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] PC_STEP    = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        interc_ready,
    input  logic        instr_valid_to_hart,
    input  logic [31:0] instr_in,
    output logic        instr_valid,
    output logic [31:0] instr_addr,
    output logic [1:0]  instr_size,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          valid_q, valid_d;
    logic          seen_rdy_q, seen_rdy_d;
    logic          seen_low_q, seen_low_d;
    logic          drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic          fv_q, fv_d;
    logic [31:0]   fi_q, fi_d;
    logic [31:0]   fp_q, fp_d;
    logic [31:0]   mem_i_q [FIFO_DEPTH];
    logic [31:0]   mem_p_q [FIFO_DEPTH];
    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] after_pop_s;

    // Request FSM: issue, detect acceptance (ready 1->0), detect response edge.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        seen_rdy_d = seen_rdy_q;
        seen_low_d = seen_low_q;
        drop_d     = drop_q;
        push_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((count_q < DEPTH_C) && !redirect) begin
                    state_d    = S_REQ;
                    addr_d     = pc_q;
                    seen_rdy_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                // A low ready before any high one means the interconnector is
                // still busy with someone else, not that it took our request.
                if (interc_ready) begin
                    seen_rdy_d = 1'b1;
                end else if (seen_rdy_q) begin
                    state_d    = S_WAIT;
                    seen_low_d = 1'b0;
                end else begin
                    state_d = S_REQ;
                end
                if (redirect) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
            end
            S_WAIT: begin
                if (seen_low_q && instr_valid_to_hart) begin
                    push_s  = !drop_q && !redirect;
                    drop_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    if (!instr_valid_to_hart) begin
                        seen_low_d = 1'b1;
                    end else begin
                        seen_low_d = seen_low_q;
                    end
                    if (redirect) begin
                        drop_d = 1'b1;
                    end else begin
                        drop_d = drop_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (redirect) begin
            pc_d = redirect_pc;
        end else if (push_s) begin
            pc_d = pc_q + PC_STEP;
        end else begin
            pc_d = pc_q;
        end

        valid_d = (state_d == S_REQ);
    end

    // FIFO bookkeeping and next registered head (flush beats pop and push).
    always_comb begin
        pop_s       = fv_q && fetch_ready;
        after_pop_s = count_q - CW'(pop_s);
        if (redirect) begin
            count_d = {CW{1'b0}};
            rd_d    = {AW{1'b0}};
            wr_d    = {AW{1'b0}};
        end else begin
            count_d = after_pop_s + CW'(push_s);
            rd_d    = rd_q + AW'(pop_s);
            wr_d    = wr_q + AW'(push_s);
        end
        fv_d = (count_d != {CW{1'b0}});
        if (!fv_d) begin
            fi_d = fi_q;
            fp_d = fp_q;
        end else if (push_s && (after_pop_s == {CW{1'b0}})) begin
            // Buffer would be empty otherwise: the word arriving now is the head.
            fi_d = instr_in;
            fp_d = pc_q;
        end else begin
            fi_d = mem_i_q[rd_d];
            fp_d = mem_p_q[rd_d];
        end
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            valid_q    <= 1'b0;
            seen_rdy_q <= 1'b0;
            seen_low_q <= 1'b0;
            drop_q     <= 1'b0;
            count_q    <= {CW{1'b0}};
            rd_q       <= {AW{1'b0}};
            wr_q       <= {AW{1'b0}};
            fv_q       <= 1'b0;
            fi_q       <= 32'h0000_0000;
            fp_q       <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            seen_rdy_q <= seen_rdy_d;
            seen_low_q <= seen_low_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            fv_q       <= fv_d;
            fi_q       <= fi_d;
            fp_q       <= fp_d;
        end
    end

    // Buffer storage; contents are only meaningful under count, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_i_q[wr_q] <= instr_in;
            mem_p_q[wr_q] <= pc_q;
        end else begin
            mem_i_q[wr_q] <= mem_i_q[wr_q];
            mem_p_q[wr_q] <= mem_p_q[wr_q];
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    // Counts pushed words and cycles spent with a request outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= 32'd0;
            perf_stall_q   <= 32'd0;
        end else begin
            perf_fetched_q <= perf_fetched_q + 32'(push_s);
            perf_stall_q   <= perf_stall_q + 32'((state_q == S_REQ) || (state_q == S_WAIT));
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

    assign instr_valid = valid_q;
    assign instr_addr  = addr_q;
    assign instr_size  = 2'd2;
    assign fetch_valid = fv_q;
    assign fetch_instr = fi_q;
    assign fetch_pc    = fp_q;

endmodule
